mem_ctrl: RTL and testbench

- Memory controller at the far end of the load/store buffer's memory request interface. It also serves the instruction-fetch port.
- Accepts one-cycle LSB request pulses (d_type != 0) and IF fetch requests. Arbitrates between them and serialises each access into byte transfers on the 8-bit RAM/IO bus.
- Returns a one-cycle read-valid pulse with raw zero-extended data, or a one-cycle write-done pulse.

---
 rtl/mem_ctrl_pkg.sv | 42 ++++
 rtl/mem_ctrl_if.sv | 48 ++++
 rtl/mem_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller slice.
//   ADDR_WIDTH / DATA_WIDTH  : request address and data widths
//   MEM_D_*                  : request size encodings (none, byte, half, word)
//   src_e                    : which requester owns the access in flight
//   mem_req_t                : one LSB request (size, direction, address, data)
//   byte_count / byte_sel    : size-to-byte-count and byte-lane helpers
package mem_ctrl_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   localparam logic [1:0] MEM_D_NONE = 2'd0;
   localparam logic [1:0] MEM_D_B    = 2'd1;
   localparam logic [1:0] MEM_D_H    = 2'd2;
   localparam logic [1:0] MEM_D_W    = 2'd3;

   typedef enum logic {
      SRC_LSB = 1'b0,
      SRC_IF  = 1'b1
   } src_e;

   typedef struct packed {
      logic [1:0]            d_type;
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } mem_req_t;

   function automatic logic [2:0] byte_count(input logic [1:0] d_type);
      case (d_type)
         MEM_D_B: return 3'd1;
         MEM_D_H: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] w,
                                           input logic [1:0] idx);
      return w[8*idx +: 8];
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the LSB request port, the instruction-fetch port,
// the UART back-pressure flag and the 8-bit RAM/IO bus.
//   slave  : the memory controller side
//   master : the requesters plus the RAM (the environment around the controller)
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   // LSB port
   logic [1:0]            lsb_d_type;
   logic                  lsb_rw;
   logic [ADDR_WIDTH-1:0] lsb_addr;
   logic [DATA_WIDTH-1:0] lsb_data;
   logic                  lsb_din_en;
   logic [DATA_WIDTH-1:0] lsb_din;
   logic                  lsb_w_done;

   // instruction-fetch port
   logic                  if_en;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [DATA_WIDTH-1:0] if_inst;

   // RAM / IO bus
   logic                  io_buffer_full;
   logic [7:0]            ram_din;
   logic [7:0]            ram_dout;
   logic [ADDR_WIDTH-1:0] ram_a;
   logic                  ram_wr;

   modport slave (
      input  lsb_d_type, lsb_rw, lsb_addr, lsb_data,
      output lsb_din_en, lsb_din, lsb_w_done,
      input  if_en, if_addr,
      output if_done, if_inst,
      input  io_buffer_full, ram_din,
      output ram_dout, ram_a, ram_wr
   );

   modport master (
      output lsb_d_type, lsb_rw, lsb_addr, lsb_data,
      input  lsb_din_en, lsb_din, lsb_w_done,
      output if_en, if_addr,
      input  if_done, if_inst,
      output io_buffer_full, ram_din,
      input  ram_dout, ram_a, ram_wr
   );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches onto the
// 8-bit RAM/IO bus.
//   clk        : system clock
//   rst_in     : asynchronous active-low reset
//   rdy_in     : global ready, low freezes every register (ram_wr forced low)
//   roll_back  : misprediction flush, aborts reads and drops a latched load
//   bus        : mem_ctrl_if.slave (LSB port, IF port, io_buffer_full, RAM bus)
// Reads: address byte j goes out at edge E(j), the RAM answers one edge later
// and the byte is captured at E(j+2); the done pulse follows E(N+1).
// Writes: one byte per cycle starting at the accept edge, done pulse after.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic      clk,
   input  logic      rst_in,
   input  logic      rdy_in,
   input  logic      roll_back,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

   // control state
   state_e                state;
   src_e                  src;
   logic [2:0]            k;
   logic [2:0]            n;
   logic                  pend_vld;

   // datapath state
   mem_req_t              pend;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [DATA_WIDTH-1:0] rdata;

   // registered outputs
   logic [ADDR_WIDTH-1:0] ram_a_q;
   logic [7:0]            ram_dout_q;
   logic                  ram_wr_q;
   logic                  lsb_din_en_q;
   logic [DATA_WIDTH-1:0] lsb_din_q;
   logic                  lsb_w_done_q;
   logic                  if_done_q;
   logic [DATA_WIDTH-1:0] if_inst_q;

   // request selection
   mem_req_t              live_req;
   logic                  live_ok;
   logic                  pend_keep;
   mem_req_t              sel_req;
   src_e                  sel_src;
   logic                  sel_vld;
   logic                  take_pend;
   logic                  take_live;
   logic                  accept;
   logic                  capture;
   logic                  io_hold_sel;
   logic                  io_hold_cur;

   logic [1:0]            rd_idx;
   logic [DATA_WIDTH-1:0] next_rdata;
   logic [ADDR_WIDTH-1:0] addr_k;

   assign live_req = '{d_type: bus.lsb_d_type, rw: bus.lsb_rw,
                       addr: bus.lsb_addr, data: bus.lsb_data};

   // Loads (live or latched) are squashed by a flush; stores always survive.
   assign live_ok   = (bus.lsb_d_type != MEM_D_NONE) && !(roll_back && !bus.lsb_rw);
   assign pend_keep = pend_vld && !(roll_back && !pend.rw);

   always_comb begin
      sel_vld   = 1'b0;
      sel_req   = live_req;
      sel_src   = SRC_LSB;
      take_pend = 1'b0;
      take_live = 1'b0;
      if (pend_keep) begin
         sel_vld   = 1'b1;
         sel_req   = pend;
         take_pend = 1'b1;
      end else if (live_ok) begin
         sel_vld   = 1'b1;
         take_live = 1'b1;
      end else if (bus.if_en && !roll_back) begin
         sel_vld = 1'b1;
         sel_src = SRC_IF;
         sel_req = '{d_type: MEM_D_W, rw: 1'b0, addr: bus.if_addr, data: '0};
      end
   end

   assign accept  = (state == IDLE) && sel_vld;
   // Any surviving LSB pulse that is not accepted right now goes to the latch.
   assign capture = live_ok && !(accept && take_live);

   assign io_hold_sel = (sel_req.addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
   assign io_hold_cur = (cur_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;

   // k runs 2..5 while bytes are captured; lane = k - 2 modulo 4.
   assign rd_idx = k[1:0] - 2'd2;
   assign addr_k = cur_addr + {{(ADDR_WIDTH-3){1'b0}}, k};

   always_comb begin
      next_rdata = rdata;
      next_rdata[8*rd_idx +: 8] = bus.ram_din;
   end

   // ---- control FSM and registered outputs ----
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         src          <= SRC_LSB;
         k            <= '0;
         n            <= '0;
         pend_vld     <= 1'b0;
         ram_a_q      <= '0;
         ram_dout_q   <= '0;
         ram_wr_q     <= 1'b0;
         lsb_din_en_q <= 1'b0;
         lsb_din_q    <= '0;
         lsb_w_done_q <= 1'b0;
         if_done_q    <= 1'b0;
         if_inst_q    <= '0;
      end else if (rdy_in) begin
         lsb_din_en_q <= 1'b0;
         lsb_w_done_q <= 1'b0;
         if_done_q    <= 1'b0;

         if (capture)
            pend_vld <= 1'b1;
         else if ((accept && take_pend) || !pend_keep)
            pend_vld <= 1'b0;

         case (state)
            IDLE: begin
               if (sel_vld) begin
                  src     <= sel_src;
                  n       <= byte_count(sel_req.d_type);
                  ram_a_q <= sel_req.addr;
                  if (sel_req.rw) begin
                     state <= WRITE;
                     if (io_hold_sel) begin
                        ram_wr_q <= 1'b0;
                        k        <= 3'd0;
                     end else begin
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= byte_sel(sel_req.data, 2'd0);
                        k          <= 3'd1;
                     end
                  end else begin
                     state    <= READ;
                     ram_wr_q <= 1'b0;
                     k        <= 3'd1;
                  end
               end
            end

            READ: begin
               if (roll_back) begin
                  state <= IDLE;
               end else begin
                  if (k < n)
                     ram_a_q <= addr_k;
                  if (k == n + 3'd1) begin
                     state <= IDLE;
                     if (src == SRC_IF) begin
                        if_done_q <= 1'b1;
                        if_inst_q <= next_rdata;
                     end else begin
                        lsb_din_en_q <= 1'b1;
                        lsb_din_q    <= next_rdata;
                     end
                  end else begin
                     k <= k + 3'd1;
                  end
               end
            end

            WRITE: begin
               // UART back-pressure stalls the byte stream without losing place.
               if (io_hold_cur) begin
                  ram_wr_q <= 1'b0;
               end else if (k < n) begin
                  ram_a_q    <= addr_k;
                  ram_dout_q <= byte_sel(cur_data, k[1:0]);
                  ram_wr_q   <= 1'b1;
                  k          <= k + 3'd1;
               end else begin
                  ram_wr_q     <= 1'b0;
                  lsb_w_done_q <= 1'b1;
                  state        <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   // ---- request payload and read assembly ----
   always_ff @(posedge clk) begin
      if (rdy_in) begin
         if (capture)
            pend <= live_req;
         if (accept) begin
            cur_addr <= sel_req.addr;
            cur_data <= sel_req.data;
            rdata    <= '0;
         end else if ((state == READ) && (k >= 3'd2)) begin
            rdata <= next_rdata;
         end
      end
   end

   assign bus.ram_a      = ram_a_q;
   assign bus.ram_dout   = ram_dout_q;
   assign bus.ram_wr     = ram_wr_q & rdy_in;
   assign bus.lsb_din_en = lsb_din_en_q;
   assign bus.lsb_din    = lsb_din_q;
   assign bus.lsb_w_done = lsb_w_done_q;
   assign bus.if_done    = if_done_q;
   assign bus.if_inst    = if_inst_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Expected load data, fetch words,
// bus writes and store completions are queued when requests are issued and
// popped by a negedge monitor when the controller produces them.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic roll_back;

   mem_ctrl_if bus();

   mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
      .clk       (clk),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .roll_back (roll_back),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_rd[$];
   logic [31:0] exp_if[$];
   logic [39:0] exp_wr[$];
   int          exp_wd[$];

   bit [7:0] mem [bit [31:0]];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Synchronous RAM, frozen by the same global ready as the controller.
   always @(posedge clk) begin
      if (rdy_in)
         bus.ram_din <= mem.exists(bus.ram_a) ? mem[bus.ram_a] : 8'h00;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.lsb_din_en) begin
         if (exp_rd.size() == 0) chk("unexp_din_en", 64'd1, 64'd0);
         else chk("lsb_din", 64'(bus.lsb_din), 64'(exp_rd.pop_front()));
      end
      if (bus.if_done) begin
         if (exp_if.size() == 0) chk("unexp_if_done", 64'd1, 64'd0);
         else chk("if_inst", 64'(bus.if_inst), 64'(exp_if.pop_front()));
      end
      if (bus.ram_wr) begin
         if (exp_wr.size() == 0) chk("unexp_ram_wr", 64'd1, 64'd0);
         else chk("ram_write", 64'({bus.ram_a, bus.ram_dout}), 64'(exp_wr.pop_front()));
      end
      if (bus.lsb_w_done) begin
         if (exp_wd.size() == 0) chk("unexp_w_done", 64'd1, 64'd0);
         else void'(exp_wd.pop_front());
      end
   end

   function automatic logic pulse(input int which);
      case (which)
         0:       return bus.lsb_din_en;
         1:       return bus.if_done;
         default: return bus.lsb_w_done;
      endcase
   endfunction

   // Waits at negedges for a pulse; n is the number of negedges waited.
   task automatic wait_pulse(input string tag, input int which, output int n);
      n = 0;
      while (n < 30 && !pulse(which)) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 64'(pulse(which)), 64'd1);
   endtask

   // Drives a one-cycle LSB pulse; returns at the negedge after the accept edge.
   task automatic lsb_req(input logic [1:0] t, input logic rw,
                          input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.lsb_d_type = t;
      bus.lsb_rw     = rw;
      bus.lsb_addr   = a;
      bus.lsb_data   = d;
      @(negedge clk);
      bus.lsb_d_type = MEM_D_NONE;
   endtask

   initial begin
      int n;
      logic [31:0] wdata;

      mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
      mem[32'h104] = 8'h55; mem[32'h105] = 8'h66; mem[32'h106] = 8'h77; mem[32'h107] = 8'h88;
      mem[32'h0]   = 8'hEF; mem[32'h1]   = 8'hBE; mem[32'h2]   = 8'hAD; mem[32'h3]   = 8'hDE;
      mem[32'h40]  = 8'h01; mem[32'h41]  = 8'h02; mem[32'h42]  = 8'h03; mem[32'h43]  = 8'h04;
      mem[32'h80]  = 8'hA1; mem[32'h81]  = 8'hB2; mem[32'h82]  = 8'hC3; mem[32'h83]  = 8'hD4;

      rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0;
      bus.lsb_d_type = MEM_D_NONE; bus.lsb_rw = 1'b0; bus.lsb_addr = '0; bus.lsb_data = '0;
      bus.if_en = 1'b0; bus.if_addr = '0; bus.io_buffer_full = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ram_wr",   64'(bus.ram_wr), 64'd0);
      chk("rst_ram_a",    64'(bus.ram_a), 64'd0);
      chk("rst_ram_dout", 64'(bus.ram_dout), 64'd0);
      chk("rst_din_en",   64'(bus.lsb_din_en), 64'd0);
      chk("rst_din",      64'(bus.lsb_din), 64'd0);
      chk("rst_w_done",   64'(bus.lsb_w_done), 64'd0);
      chk("rst_if_done",  64'(bus.if_done), 64'd0);
      chk("rst_if_inst",  64'(bus.if_inst), 64'd0);
      rst_in = 1'b1;
      repeat (2) @(negedge clk);

      // word load: address walk and 5-edge latency
      exp_rd.push_back(32'h44332211);
      lsb_req(MEM_D_W, 1'b0, 32'h100, 32'h0);
      for (int j = 0; j < 4; j++) begin
         if (j > 0) @(negedge clk);
         chk("ld_ram_a", 64'(bus.ram_a), 64'(32'h100 + j));
         chk("ld_ram_wr", 64'(bus.ram_wr), 64'd0);
      end
      wait_pulse("ld_pulse", 0, n);
      chk("ld_latency", 64'(n), 64'd2);
      @(negedge clk);

      // IO byte store throttled by io_buffer_full for 3 cycles
      @(negedge clk);
      bus.io_buffer_full = 1'b1;
      exp_wr.push_back({32'h30004, 8'hA5});
      exp_wd.push_back(1);
      lsb_req(MEM_D_B, 1'b1, 32'h30004, 32'h000000A5);
      chk("io_hold0", 64'(bus.ram_wr), 64'd0);
      @(negedge clk);
      chk("io_hold1", 64'(bus.ram_wr), 64'd0);
      @(negedge clk);
      chk("io_hold2", 64'(bus.ram_wr), 64'd0);
      bus.io_buffer_full = 1'b0;
      @(negedge clk);
      chk("io_write", 64'(bus.ram_wr), 64'd1);
      wait_pulse("io_w_done", 2, n);
      chk("io_wd_lat", 64'(n), 64'd1);

      // fetch with a half load arriving two cycles later (served from the latch)
      @(negedge clk);
      bus.if_en = 1'b1; bus.if_addr = 32'h0;
      exp_if.push_back(32'hDEADBEEF);
      repeat (2) @(negedge clk);
      bus.lsb_d_type = MEM_D_H; bus.lsb_rw = 1'b0; bus.lsb_addr = 32'h105;
      exp_rd.push_back(32'h00007766);
      @(negedge clk);
      bus.lsb_d_type = MEM_D_NONE;
      wait_pulse("if_pulse", 1, n);
      chk("if_latency", 64'(n), 64'd3);
      bus.if_en = 1'b0;
      @(negedge clk);
      chk("pend_start", 64'(bus.ram_a), 64'(32'h105));
      wait_pulse("half_pulse", 0, n);
      chk("half_latency", 64'(n), 64'd3);

      // roll_back mid fetch, then a new fetch from byte 0
      @(negedge clk);
      bus.if_en = 1'b1; bus.if_addr = 32'h40;
      repeat (4) @(negedge clk);
      roll_back = 1'b1; bus.if_addr = 32'h80;
      @(negedge clk);
      roll_back = 1'b0;
      chk("rb_no_done", 64'(bus.if_done), 64'd0);
      chk("rb_ram_a", 64'(bus.ram_a), 64'(32'h43));
      exp_if.push_back(32'hD4C3B2A1);
      @(negedge clk);
      chk("refetch_a", 64'(bus.ram_a), 64'(32'h80));
      wait_pulse("refetch_pulse", 1, n);
      chk("refetch_lat", 64'(n), 64'd5);
      bus.if_en = 1'b0;

      // if_en during roll_back in IDLE is ignored
      @(negedge clk);
      roll_back = 1'b1; bus.if_en = 1'b1; bus.if_addr = 32'hC0;
      @(negedge clk);
      roll_back = 1'b0; bus.if_en = 1'b0;
      chk("rb_if_ign", 64'(bus.ram_a), 64'(32'h83));
      repeat (6) @(negedge clk);

      // word store survives roll_back
      wdata = 32'h0D0C0B0A;
      for (int j = 0; j < 4; j++) exp_wr.push_back({32'h200 + j, wdata[8*j +: 8]});
      exp_wd.push_back(1);
      lsb_req(MEM_D_W, 1'b1, 32'h200, wdata);
      roll_back = 1'b1;
      repeat (2) @(negedge clk);
      roll_back = 1'b0;
      wait_pulse("st_w_done", 2, n);
      chk("st_wd_lat", 64'(n), 64'd2);

      // rdy_in low for 2 cycles during a word load
      exp_rd.push_back(32'h44332211);
      lsb_req(MEM_D_W, 1'b0, 32'h100, 32'h0);
      @(negedge clk);
      rdy_in = 1'b0;
      repeat (2) @(negedge clk);
      rdy_in = 1'b1;
      wait_pulse("stall_pulse", 0, n);
      chk("stall_latency", 64'(n), 64'd4);

      // rdy_in gating of ram_wr, then asynchronous reset mid store
      @(negedge clk);
      exp_wr.push_back({32'h300, 8'h01});
      exp_wr.push_back({32'h301, 8'h02});
      lsb_req(MEM_D_W, 1'b1, 32'h300, 32'h04030201);
      #2 rdy_in = 1'b0;
      #1 chk("rdy_force", 64'(bus.ram_wr), 64'd0);
      rdy_in = 1'b1;
      #1 chk("rdy_back", 64'(bus.ram_wr), 64'd1);
      @(negedge clk);
      #2 rst_in = 1'b0;
      #1;
      chk("arst_ram_wr", 64'(bus.ram_wr), 64'd0);
      chk("arst_ram_a",  64'(bus.ram_a), 64'd0);
      chk("arst_w_done", 64'(bus.lsb_w_done), 64'd0);
      chk("arst_din_en", 64'(bus.lsb_din_en), 64'd0);
      repeat (2) @(negedge clk);
      rst_in = 1'b1;
      repeat (8) @(negedge clk);

      // controller is IDLE after reset: a fresh load has normal latency
      exp_rd.push_back(32'h88776655);
      lsb_req(MEM_D_W, 1'b0, 32'h104, 32'h0);
      wait_pulse("post_rst_pulse", 0, n);
      chk("post_rst_lat", 64'(n), 64'd5);
      repeat (3) @(negedge clk);

      chk("rd_q_empty", 64'(exp_rd.size()), 64'd0);
      chk("if_q_empty", 64'(exp_if.size()), 64'd0);
      chk("wr_q_empty", 64'(exp_wr.size()), 64'd0);
      chk("wd_q_empty", 64'(exp_wd.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
